btn_arbiter: RTL and testbench

Shared-timer debounce controller for the board's push-buttons. It synchronizes N raw button inputs. It grants a single settle counter to one changed button at a time in round-robin order, and publishes each confirmed press or release as an event on a valid/ready handshake to the game/UI logic. This replaces per-button debounce counters: the design holds one counter instead of N.

---
 rtl/btn_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_btn_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_arbiter.sv
// ---------------------------------------------------------------------------
// btn_arbiter
//
// Debounce controller for the board push-buttons that shares one settle
// counter between all buttons. Each raw button is synchronized, and a
// changed button is granted the counter in round-robin order. Once its new
// level has held for SETTLE_CYCLES cycles, the change is accepted. The
// accepted change is published as an event on a valid/ready handshake.
//
// Parameters:
//   N_BTN          number of raw buttons (2..8)
//   ID_W           width of evt_id (2**ID_W >= N_BTN)
//   SETTLE_CYCLES  cycles a changed level must hold before acceptance (>= 2)
//   CNT_W          settle counter width (must hold SETTLE_CYCLES-1)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   btn        raw asynchronous button levels, 1 = pressed
//   btn_state  debounced button levels
//   evt_valid  an event is presented
//   evt_ready  consumer accepts the event
//   evt_id     index of the button that produced the event
//   evt_press  1 = press, 0 = release
//   busy       arbiter is serving a button (not idle)
//
// Optional feature macro: BTN_ARBITER_RELEASE_EVT_EN
//   defined   : releases are reported as events with evt_press = 0
//   undefined : releases update btn_state silently and evt_press is tied to 1
// ---------------------------------------------------------------------------
module btn_arbiter #(
   parameter int N_BTN         = 4,
   parameter int ID_W          = 2,
   parameter int SETTLE_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] btn_state,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output logic             evt_press,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [N_BTN-1:0] sync_meta;
   logic [N_BTN-1:0] sync;
   logic [N_BTN-1:0] pending;
   logic [ID_W-1:0]  rr;
   logic [ID_W-1:0]  sel;
   logic [ID_W-1:0]  sel_inc;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_found;
   logic [CNT_W-1:0] cnt;
   logic             sel_sync;
   logic             sel_state;
   logic             do_grant;
   logic             do_bounce;
   logic             do_accept;
   logic             do_report;
   logic             do_handshake;
   logic             rr_advance;

   // A button needs service whenever its synchronized level disagrees with
   // its debounced level; nothing is remembered, so a change that reverts
   // before it is served simply disappears.
   assign pending   = sync ^ btn_state;
   assign sel_sync  = sync[sel];
   assign sel_state = btn_state[sel];
   assign sel_inc   = (sel == ID_W'(N_BTN - 1)) ? '0 : sel + 1'b1;

   // Round-robin search: walk the buttons starting at rr, wrapping modulo
   // N_BTN, and pick the first one that is pending.
   always_comb begin
      logic [ID_W-1:0] idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int k = 0; k < N_BTN; k++) begin
         idx = ID_W'((int'(rr) + k) % N_BTN);
         if (!grant_found && pending[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   // Next-state logic. The strobes below tell the datapath what happened
   // this cycle: grant, bounce-back, accepted change, event publish, and
   // consumer handshake.
   always_comb begin
      state_next   = state;
      do_grant     = 1'b0;
      do_bounce    = 1'b0;
      do_accept    = 1'b0;
      do_report    = 1'b0;
      do_handshake = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               do_grant   = 1'b1;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (sel_sync == sel_state) begin
               do_bounce  = 1'b1;
               state_next = IDLE;
            end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               do_accept = 1'b1;
`ifdef BTN_ARBITER_RELEASE_EVT_EN
               do_report  = 1'b1;
               state_next = REPORT;
`else
               if (sel_sync) begin
                  do_report  = 1'b1;
                  state_next = REPORT;
               end else begin
                  state_next = IDLE;
               end
`endif
            end
         end
         REPORT: begin
            if (evt_valid && evt_ready) begin
               do_handshake = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The pointer moves past the served button whenever its grant ends,
   // whatever the reason.
   assign rr_advance = do_bounce | do_handshake | (do_accept & ~do_report);

   // State register; busy is registered alongside so it lines up exactly
   // with the state it describes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   // Two-flop synchronizer for the raw asynchronous button inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= btn;
         sync      <= sync_meta;
      end
   end

   // Shared settle counter, grant bookkeeping, debounced levels and the
   // event registers. An accepted change always differs from the old
   // debounced level, so flipping the selected bit stores the new level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel       <= '0;
         rr        <= '0;
         cnt       <= '0;
         btn_state <= '0;
         evt_valid <= 1'b0;
         evt_id    <= '0;
      end else begin
         if (do_grant) begin
            sel <= grant_idx;
            cnt <= '0;
         end else if (state == SETTLE) begin
            cnt <= cnt + 1'b1;
         end
         if (rr_advance) begin
            rr <= sel_inc;
         end
         if (do_accept) begin
            btn_state <= btn_state ^ (N_BTN'(1) << sel);
         end
         if (do_report) begin
            evt_valid <= 1'b1;
            evt_id    <= sel;
         end else if (do_handshake) begin
            evt_valid <= 1'b0;
         end
      end
   end

`ifdef BTN_ARBITER_RELEASE_EVT_EN
   // Press/release direction of the published event.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt_press <= 1'b0;
      end else if (do_report) begin
         evt_press <= sel_sync;
      end
   end
`else
   // Only presses are ever published, so the direction is constant.
   assign evt_press = 1'b1;
`endif

endmodule

// File: tb/tb_btn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_btn_arbiter
//
// Self-checking bench for btn_arbiter with N_BTN = 4 and SETTLE_CYCLES = 8.
// A behavioural model tracks the synchronized levels, the button currently
// being served and how long its new level has held. It is compared against
// every DUT output on each falling edge. Directed scenarios also pin event
// timing and identities to hand-computed constants.
// Honours BTN_ARBITER_RELEASE_EVT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_btn_arbiter;

   localparam int N      = 4;
   localparam int SETTLE = 8;
`ifdef BTN_ARBITER_RELEASE_EVT_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn = 4'b0000;
   logic       evt_ready = 1'b1;
   logic [3:0] btn_state;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_press;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   btn_arbiter #(
      .N_BTN(N),
      .ID_W(2),
      .SETTLE_CYCLES(SETTLE),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn(btn),
      .btn_state(btn_state),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_id(evt_id),
      .evt_press(evt_press),
      .busy(busy)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive new button levels and consumer readiness on a falling edge.
   task automatic applyStimulus(input logic [3:0] b, input logic rdy);
      @(negedge clk);
      btn       = b;
      evt_ready = rdy;
   endtask

   // Count rising edges until evt_valid is seen high just after an edge.
   // The wait is bounded; running out counts as a failed check.
   task automatic waitValid(output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!evt_valid && edges < 60);
      if (!evt_valid) checkOutput("wait_valid_timeout", 32'(0), 32'(1));
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b1;
      btn   = 4'b0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Behavioural model. owner = button being served (-1 none), age = edges
   // its new level has been watched since the grant, reporting = waiting
   // for the consumer.
   // ------------------------------------------------------------------
   logic [3:0] m_s1, m_s2, m_st;
   int         m_owner, m_age, m_rr, m_id;
   bit         m_reporting;
   logic       m_valid, m_press;

   always @(posedge clk) begin
      if (reset) begin
         m_s1 = 4'b0; m_s2 = 4'b0; m_st = 4'b0;
         m_owner = -1; m_age = 0; m_rr = 0; m_id = 0;
         m_reporting = 1'b0; m_valid = 1'b0; m_press = 1'b0;
      end else begin
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
               if (m_owner < 0 && m_s2[(m_rr + k) % N] != m_st[(m_rr + k) % N]) begin
                  m_owner = (m_rr + k) % N;
                  m_age   = 0;
               end
            end
         end else if (!m_reporting) begin
            if (m_s2[m_owner] == m_st[m_owner]) begin
               m_rr    = (m_owner + 1) % N;
               m_owner = -1;
            end else if (m_age == SETTLE - 1) begin
               m_st[m_owner] = m_s2[m_owner];
               if (m_s2[m_owner] || REL_EN) begin
                  m_reporting = 1'b1;
                  m_valid     = 1'b1;
                  m_id        = m_owner;
                  m_press     = m_s2[m_owner];
               end else begin
                  m_rr    = (m_owner + 1) % N;
                  m_owner = -1;
               end
            end else begin
               m_age++;
            end
         end else if (evt_ready) begin
            m_valid     = 1'b0;
            m_reporting = 1'b0;
            m_rr        = (m_owner + 1) % N;
            m_owner     = -1;
         end
         m_s2 = m_s1;
         m_s1 = btn;
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("model_btn_state", 32'(btn_state), 32'(m_st));
         checkOutput("model_evt_valid", 32'(evt_valid), 32'(m_valid));
         checkOutput("model_evt_id", 32'(evt_id), 32'(m_id));
         checkOutput("model_evt_press", 32'(evt_press), REL_EN ? 32'(m_press) : 32'(1));
         checkOutput("model_busy", 32'(busy), 32'(m_owner >= 0));
      end
   end

   // Directed scenarios with hand-computed expectations.
   initial begin
      int e, e2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      reset  = 1'b0;
      checkOutput("reset_btn_state", 32'(btn_state), 32'(0));
      checkOutput("reset_evt_valid", 32'(evt_valid), 32'(0));
      checkOutput("reset_busy", 32'(busy), 32'(0));
      checkOutput("reset_evt_id", 32'(evt_id), 32'(0));
      checkOutput("reset_evt_press", 32'(evt_press), REL_EN ? 32'(0) : 32'(1));

      $display("[TB] clean press");
      applyStimulus(4'b0100, 1'b1);
      waitValid(e);
      checkOutput("press_latency", 32'(e), 32'(11));
      checkOutput("press_id", 32'(evt_id), 32'(2));
      checkOutput("press_dir", 32'(evt_press), 32'(1));
      checkOutput("press_state", 32'(btn_state), 32'(4'b0100));
      @(posedge clk); #1;
      checkOutput("press_pulse", 32'(evt_valid), 32'(0));

      $display("[TB] bounce");
      applyStimulus(4'b0110, 1'b1);
      applyStimulus(4'b0110, 1'b1);
      applyStimulus(4'b0110, 1'b1);
      applyStimulus(4'b0100, 1'b1);
      applyStimulus(4'b0100, 1'b1);
      checkOutput("bounce_state_held", 32'(btn_state), 32'(4'b0100));
      applyStimulus(4'b0110, 1'b1);
      waitValid(e);
      checkOutput("bounce_latency", 32'(e), 32'(11));
      checkOutput("bounce_id", 32'(evt_id), 32'(1));
      checkOutput("bounce_dir", 32'(evt_press), 32'(1));
      checkOutput("bounce_state", 32'(btn_state), 32'(4'b0110));
      @(posedge clk); #1;

      $display("[TB] simultaneous changes and fairness");
      applyReset();
      applyStimulus(4'b1001, 1'b1);
      waitValid(e);
      checkOutput("simul_first_edge", 32'(e), 32'(11));
      checkOutput("simul_first_id", 32'(evt_id), 32'(0));
      waitValid(e2);
      checkOutput("simul_second_edge", 32'(e + e2), 32'(21));
      checkOutput("simul_second_id", 32'(evt_id), 32'(3));
      @(posedge clk); #1;
      applyStimulus(4'b0000, 1'b1);
      repeat (40) @(negedge clk);
      checkOutput("simul_released", 32'(btn_state), 32'(0));
      applyStimulus(4'b1001, 1'b1);
      waitValid(e);
      checkOutput("wrap_first_id", 32'(evt_id), 32'(0));
      waitValid(e2);
      checkOutput("wrap_second_id", 32'(evt_id), 32'(3));
      @(posedge clk); #1;
      checkOutput("wrap_pulse", 32'(evt_valid), 32'(0));

      $display("[TB] backpressure");
      applyStimulus(4'b1011, 1'b0);
      waitValid(e);
      checkOutput("stall_latency", 32'(e), 32'(11));
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 5) btn = 4'b1111;
         checkOutput("stall_valid", 32'(evt_valid), 32'(1));
         checkOutput("stall_id", 32'(evt_id), 32'(1));
         checkOutput("stall_busy", 32'(busy), 32'(1));
      end
      applyStimulus(4'b1111, 1'b1);
      @(posedge clk); #1;
      checkOutput("stall_release", 32'(evt_valid), 32'(0));
      waitValid(e2);
      checkOutput("stall_next_edge", 32'(1 + e2), 32'(10));
      checkOutput("stall_next_id", 32'(evt_id), 32'(2));
      @(posedge clk); #1;

      $display("[TB] release");
      applyStimulus(4'b1011, 1'b1);
      if (REL_EN) begin
         waitValid(e);
         checkOutput("release_latency", 32'(e), 32'(11));
         checkOutput("release_id", 32'(evt_id), 32'(2));
         checkOutput("release_dir", 32'(evt_press), 32'(0));
         checkOutput("release_state", 32'(btn_state), 32'(4'b1011));
         @(posedge clk); #1;
      end else begin
         repeat (10) @(posedge clk);
         #1;
         checkOutput("release_before", 32'(btn_state), 32'(4'b1111));
         @(posedge clk); #1;
         checkOutput("release_state", 32'(btn_state), 32'(4'b1011));
         checkOutput("release_no_evt", 32'(evt_valid), 32'(0));
      end

      $display("[TB] reset mid-operation");
      applyStimulus(4'b1000, 1'b1);
      repeat (40) @(negedge clk);
      checkOutput("pre_reset_state", 32'(btn_state), 32'(4'b1000));
      applyStimulus(4'b1010, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("pre_reset_busy", 32'(busy), 32'(1));
      @(negedge clk);
      reset = 1'b1;
      btn   = 4'b1000;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_btn_state", 32'(btn_state), 32'(0));
      checkOutput("rst_evt_valid", 32'(evt_valid), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_evt_id", 32'(evt_id), 32'(0));
      waitValid(e);
      checkOutput("rst_press_latency", 32'(e), 32'(11));
      checkOutput("rst_press_id", 32'(evt_id), 32'(3));
      checkOutput("rst_press_dir", 32'(evt_press), 32'(1));
      @(posedge clk); #1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
